// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } pipe_state_e;

    localparam int unsigned DEF_DRAIN_CYCLES = 3;
    localparam int unsigned DEF_MEM_TIMEOUT  = 64;
    localparam int unsigned DEF_CNT_W        = 32;
    localparam int unsigned SAT_MAX_W        = 64;

    // Increment that sticks at max_val; callers zero-extend into SAT_MAX_W bits.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                     input logic [SAT_MAX_W-1:0] max_val);
        return (val >= max_val) ? max_val : val + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/pipe_perf_counters.sv
// Saturating stall / flush / memory-wait event counters.
module pipe_perf_counters
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_evt,
    input  logic             flush_evt,
    input  logic             wait_evt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] mem_wait_cycles
);

    localparam logic [SAT_MAX_W-1:0] CNT_MAX = SAT_MAX_W'({CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles    <= '0;
            flush_count     <= '0;
            mem_wait_cycles <= '0;
        end else begin
            if (stall_evt) stall_cycles    <= CNT_W'(sat_inc(SAT_MAX_W'(stall_cycles), CNT_MAX));
            if (flush_evt) flush_count     <= CNT_W'(sat_inc(SAT_MAX_W'(flush_count), CNT_MAX));
            if (wait_evt)  mem_wait_cycles <= CNT_W'(sat_inc(SAT_MAX_W'(mem_wait_cycles), CNT_MAX));
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: hazards, mispredicts, memory freeze, halt drain.
// Define PIPE_PERF_CNT_EN to build the performance counters; otherwise they read as zero.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int unsigned MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_stall,
    input  logic             ex_mispredict,
    input  logic             id_is_halt,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             mem_wb_bubble,
    output logic             is_halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] mem_wait_cycles
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int unsigned WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    pipe_state_e        state, state_nxt;
    pipe_state_e        ret_state, ret_nxt;
    pipe_state_e        eff_state;
    logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic               frozen;
    logic               halt_set;

    // A wait release behaves exactly like the state we froze out of.
    assign eff_state = (state == MEM_WAIT) ? ret_state : state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            ret_state   <= RUN;
            drain_cnt   <= '0;
            wait_cnt    <= '0;
            is_halted   <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            drain_cnt <= drain_nxt;
            wait_cnt  <= wait_nxt;
            if (halt_set) is_halted <= 1'b1;
            if (frozen && (wait_nxt == WAIT_MAX)) mem_timeout <= 1'b1;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_write  = 1'b0;
        mem_wb_bubble = 1'b0;
        state_nxt     = state;
        ret_nxt       = ret_state;
        drain_nxt     = drain_cnt;
        wait_nxt      = '0;
        frozen        = 1'b0;
        halt_set      = 1'b0;

        if (reset && (state != HALTED)) begin
            if (dmem_req && !dmem_ready) begin
                // Data memory busy: hold everything, push a bubble into WB.
                frozen        = 1'b1;
                mem_wb_write  = 1'b1;
                mem_wb_bubble = 1'b1;
                state_nxt     = MEM_WAIT;
                if (state == MEM_WAIT) begin
                    wait_nxt = (wait_cnt >= WAIT_MAX) ? WAIT_MAX : wait_cnt + WAIT_W'(1);
                end else begin
                    ret_nxt  = state;
                    wait_nxt = WAIT_W'(1);
                end
            end else begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_write  = 1'b1;
                ex_mem_write = 1'b1;
                mem_wb_write = 1'b1;
                state_nxt    = eff_state;
                if (eff_state == DRAIN) begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    if (drain_cnt <= DRAIN_W'(1)) begin
                        drain_nxt = '0;
                        state_nxt = HALTED;
                        halt_set  = 1'b1;
                    end else begin
                        drain_nxt = drain_cnt - DRAIN_W'(1);
                    end
                end else if (ex_mispredict) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (id_is_halt && !hazard_stall) begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    drain_nxt   = DRAIN_W'(DRAIN_CYCLES);
                    state_nxt   = DRAIN;
                end else if (hazard_stall) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (!imem_ready) begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                end
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic run_live;
    logic stall_evt;
    logic flush_evt;

    assign run_live  = reset && (state != HALTED) && !frozen && (eff_state == RUN);
    assign stall_evt = run_live && !ex_mispredict && hazard_stall;
    assign flush_evt = run_live && ex_mispredict;

    pipe_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk             (clk),
        .rst_n           (reset),
        .stall_evt       (stall_evt),
        .flush_evt       (flush_evt),
        .wait_evt        (frozen),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .mem_wait_cycles (mem_wait_cycles)
    );
`else
    assign stall_cycles    = '0;
    assign flush_count     = '0;
    assign mem_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

    localparam int unsigned DRAIN = 3;
    localparam int unsigned TMO   = 64;
    localparam int unsigned CW    = 32;

    logic clk = 1'b0;
    logic reset;
    logic hazard_stall, ex_mispredict, id_is_halt, imem_ready, dmem_req, dmem_ready;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic ex_mem_write, mem_wb_write, mem_wb_bubble, is_halted, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_count, mem_wait_cycles;
    logic [7:0] got_ctrl;

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .DRAIN_CYCLES (DRAIN),
        .MEM_TIMEOUT  (TMO),
        .CNT_W        (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .hazard_stall    (hazard_stall),
        .ex_mispredict   (ex_mispredict),
        .id_is_halt      (id_is_halt),
        .imem_ready      (imem_ready),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_write     (id_ex_write),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_write    (ex_mem_write),
        .mem_wb_write    (mem_wb_write),
        .mem_wb_bubble   (mem_wb_bubble),
        .is_halted       (is_halted),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .mem_wait_cycles (mem_wait_cycles)
    );

    // Bit order: pc, if_id_w, if_id_flush, id_ex_w, id_ex_bubble, ex_mem_w, mem_wb_w, mem_wb_bubble
    assign got_ctrl = {pc_write, if_id_write, if_id_flush, id_ex_write,
                       id_ex_bubble, ex_mem_write, mem_wb_write, mem_wb_bubble};

    int checks = 0;
    int errors = 0;

    // Behavioural model: freeze is an overlay, draining is a countdown of unfrozen cycles.
    bit          m_halted, m_draining, m_timeout;
    int          m_drain_left, m_wait_n;
    logic [31:0] m_stall, m_flush, m_wait;

    function automatic logic [7:0] model_ctrl();
        if (!reset || m_halted)          return 8'b0000_0000;
        if (dmem_req && !dmem_ready)     return 8'b0000_0011;
        if (m_draining)                  return 8'b0111_0110;
        if (ex_mispredict)               return 8'b1111_1110;
        if (id_is_halt && !hazard_stall) return 8'b0111_0110;
        if (hazard_stall)                return 8'b0001_1110;
        if (!imem_ready)                 return 8'b0111_0110;
        return 8'b1101_0110;
    endfunction

    function automatic logic [CW-1:0] exp_cnt(input logic [31:0] v);
`ifdef PIPE_PERF_CNT_EN
        return CW'(v);
`else
        return (v == 32'hFFFF_FFFF) ? '0 : '0;
`endif
    endfunction

    task automatic model_reset();
        m_halted = 0; m_draining = 0; m_timeout = 0;
        m_drain_left = 0; m_wait_n = 0;
        m_stall = '0; m_flush = '0; m_wait = '0;
    endtask

    task automatic model_step();
        if (!reset) begin model_reset(); return; end
        if (m_halted) return;
        if (dmem_req && !dmem_ready) begin
            m_wait_n++;
            if (m_wait_n >= TMO) m_timeout = 1;
            if (m_wait != '1) m_wait++;
            return;
        end
        m_wait_n = 0;
        if (m_draining) begin
            m_drain_left--;
            if (m_drain_left <= 0) begin m_draining = 0; m_halted = 1; end
        end else if (ex_mispredict) begin
            if (m_flush != '1) m_flush++;
        end else if (id_is_halt && !hazard_stall) begin
            m_draining = 1; m_drain_left = DRAIN;
        end else if (hazard_stall) begin
            if (m_stall != '1) m_stall++;
        end
    endtask

    task automatic set_in(input logic h, input logic m, input logic hl,
                          input logic im, input logic rq, input logic rd);
        hazard_stall = h; ex_mispredict = m; id_is_halt = hl;
        imem_ready = im; dmem_req = rq; dmem_ready = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_in(0, 0, 0, 1, 0, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        model_reset();
        #2;
        checks++; if (got_ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %b exp %b", got_ctrl, 8'h00); end
        checks++; if (is_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", is_halted); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", mem_timeout); end
        checks++; if ({stall_cycles, flush_count, mem_wait_cycles} !== '0) begin
            errors++; $display("FAIL reset_counters got %0d %0d %0d exp 0", stall_cycles, flush_count, mem_wait_cycles);
        end
        @(negedge clk);
        reset = 1'b1;
        set_in(0, 0, 0, 1, 0, 0);
        tick();
        @(negedge clk);
        checks++; if (got_ctrl !== model_ctrl()) begin errors++; $display("FAIL post_reset_ctrl got %b exp %b", got_ctrl, model_ctrl()); end
    endtask

    task automatic test_hazard();
        do_reset();
        set_in(1, 0, 0, 1, 0, 0);
        @(negedge clk);
        checks++; if (got_ctrl !== model_ctrl()) begin errors++; $display("FAIL hazard_ctrl got %b exp %b", got_ctrl, model_ctrl()); end
        tick();
        set_in(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        checks++; if (got_ctrl !== model_ctrl()) begin errors++; $display("FAIL hazard_after got %b exp %b", got_ctrl, model_ctrl()); end
        checks++; if (stall_cycles !== exp_cnt(m_stall)) begin errors++; $display("FAIL hazard_stall_cnt got %0d exp %0d", stall_cycles, exp_cnt(m_stall)); end
        tick();
    endtask

    task automatic test_mem_freeze();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b1, (i == 4));
            @(negedge clk);
            checks++; if (got_ctrl !== model_ctrl()) begin errors++; $display("FAIL freeze_ctrl[%0d] got %b exp %b", i, got_ctrl, model_ctrl()); end
            tick();
        end
        set_in(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        checks++; if (mem_wait_cycles !== exp_cnt(m_wait)) begin errors++; $display("FAIL freeze_wait_cnt got %0d exp %0d", mem_wait_cycles, exp_cnt(m_wait)); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL freeze_no_timeout got %b exp 0", mem_timeout); end
    endtask

    task automatic test_mispredict();
        do_reset();
        set_in(1, 1, 1, 0, 0, 0);
        @(negedge clk);
        checks++; if (got_ctrl !== model_ctrl()) begin errors++; $display("FAIL mispredict_ctrl got %b exp %b", got_ctrl, model_ctrl()); end
        tick();
        // Mispredict coinciding with a freeze: freeze first, then flush on release.
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 0, 1, 1, (i == 2));
            @(negedge clk);
            checks++; if (got_ctrl !== model_ctrl()) begin errors++; $display("FAIL mispredict_freeze[%0d] got %b exp %b", i, got_ctrl, model_ctrl()); end
            tick();
        end
        set_in(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        checks++; if (flush_count !== exp_cnt(m_flush)) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", flush_count, exp_cnt(m_flush)); end
        checks++; if (stall_cycles !== exp_cnt(m_stall)) begin errors++; $display("FAIL mispredict_stall_cnt got %0d exp %0d", stall_cycles, exp_cnt(m_stall)); end
    endtask

    task automatic test_halt_drain();
        logic [1:0] seq [8];
        seq = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b00, 2'b10, 2'b00};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in((i > 0), (i > 0), (i == 0), 1'b1, seq[i][1], seq[i][0]);
            @(negedge clk);
            checks++; if (got_ctrl !== model_ctrl()) begin errors++; $display("FAIL drain_ctrl[%0d] got %b exp %b", i, got_ctrl, model_ctrl()); end
            checks++; if (is_halted !== m_halted) begin errors++; $display("FAIL drain_halted[%0d] got %b exp %b", i, is_halted, m_halted); end
            tick();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        set_in(0, 0, 0, 1, 1, 0);
        for (int i = 0; i <= TMO; i++) begin
            @(negedge clk);
            checks++; if (mem_timeout !== m_timeout) begin errors++; $display("FAIL timeout[%0d] got %b exp %b", i, mem_timeout, m_timeout); end
            if (i < TMO) tick();
        end
        dmem_ready = 1'b1;
        tick();
        set_in(0, 0, 0, 1, 0, 0);
        tick();
        @(negedge clk);
        checks++; if (mem_timeout !== m_timeout) begin errors++; $display("FAIL timeout_sticky got %b exp %b", mem_timeout, m_timeout); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_in(0, 0, 1, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 0, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (got_ctrl !== model_ctrl()) begin errors++; $display("FAIL areset_drain_ctrl got %b exp %b", got_ctrl, model_ctrl()); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (got_ctrl !== model_ctrl()) begin errors++; $display("FAIL areset_drain_run got %b exp %b", got_ctrl, model_ctrl()); end
        checks++; if (is_halted !== m_halted) begin errors++; $display("FAIL areset_drain_halted got %b exp %b", is_halted, m_halted); end
        tick();
        set_in(0, 0, 0, 1, 1, 0);
        repeat (TMO + 2) tick();
        checks++; if (mem_timeout !== m_timeout) begin errors++; $display("FAIL areset_pre_timeout got %b exp %b", mem_timeout, m_timeout); end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (mem_timeout !== m_timeout) begin errors++; $display("FAIL areset_wait_timeout got %b exp %b", mem_timeout, m_timeout); end
        checks++; if (got_ctrl !== model_ctrl()) begin errors++; $display("FAIL areset_wait_ctrl got %b exp %b", got_ctrl, model_ctrl()); end
        checks++; if (mem_wait_cycles !== exp_cnt(m_wait)) begin errors++; $display("FAIL areset_wait_cnt got %0d exp %0d", mem_wait_cycles, exp_cnt(m_wait)); end
        @(negedge clk);
        reset = 1'b1;
        set_in(0, 0, 0, 1, 0, 0);
        tick();
        @(negedge clk);
        checks++; if (got_ctrl !== model_ctrl()) begin errors++; $display("FAIL areset_wait_run got %b exp %b", got_ctrl, model_ctrl()); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (m_halted && ($urandom_range(0, 3) == 0)) do_reset();
            set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 2) == 0), 1'($urandom));
            @(negedge clk);
            checks++; if (got_ctrl !== model_ctrl()) begin errors++; $display("FAIL rand_ctrl[%0d] got %b exp %b", n, got_ctrl, model_ctrl()); end
            checks++; if (is_halted !== m_halted) begin errors++; $display("FAIL rand_halted[%0d] got %b exp %b", n, is_halted, m_halted); end
            checks++; if (mem_timeout !== m_timeout) begin errors++; $display("FAIL rand_timeout[%0d] got %b exp %b", n, mem_timeout, m_timeout); end
            checks++; if (stall_cycles !== exp_cnt(m_stall)) begin errors++; $display("FAIL rand_stall[%0d] got %0d exp %0d", n, stall_cycles, exp_cnt(m_stall)); end
            checks++; if (flush_count !== exp_cnt(m_flush)) begin errors++; $display("FAIL rand_flush[%0d] got %0d exp %0d", n, flush_count, exp_cnt(m_flush)); end
            checks++; if (mem_wait_cycles !== exp_cnt(m_wait)) begin errors++; $display("FAIL rand_wait[%0d] got %0d exp %0d", n, mem_wait_cycles, exp_cnt(m_wait)); end
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hazard();
        test_mem_freeze();
        test_mispredict();
        test_halt_drain();
        test_timeout();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Sits between the stall sources and the per-stage pipeline-register write/flush controls. Sources: load-use/ECALL hazard request from ID, branch mispredict from EX, instruction/data memory readiness.
- Arbitrates the sources by fixed priority, freezes the pipeline on multi-cycle data-memory access, drains the pipeline on a halting ECALL, and raises is_halted.

Parameters:
- DRAIN_CYCLES, 3, cycles from halting ECALL leaving ID until it retires from WB (counted only on non-frozen cycles).
- MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before sticky mem_timeout is set.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- hazard_stall  in  1  load-use/ECALL data hazard in ID (registered upstream, level)
- ex_mispredict  in  1  branch/jump in EX resolved to a PC other than the predicted one
- id_is_halt  in  1  ID holds ECALL with forwarded x17==10
- imem_ready  in  1  instruction fetch data valid this cycle
- dmem_req  in  1  MEM stage performs a load/store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_write  out  1  ID/EX enable
- id_ex_bubble  out  1  ID/EX loads a NOP (control bits zeroed)
- ex_mem_write  out  1  EX/MEM enable
- mem_wb_write  out  1  MEM/WB enable
- mem_wb_bubble  out  1  MEM/WB loads a NOP
- is_halted  out  1  registered; pipeline drained after halting ECALL
- mem_timeout  out  1  registered sticky error
- stall_cycles, flush_count, mem_wait_cycles  out  CNT_W each  performance counters (see Optional Feature)

Behaviour:
- Reset (reset==0, asynchronous):
  - State goes to RUN; drain counter, wait counter, is_halted, mem_timeout and perf counters are cleared.
  - While reset is low, all *_write outputs are 0 and all flush/bubble outputs are 0.
- FSM states are RUN, MEM_WAIT, DRAIN, HALTED. Control outputs are combinational from state and inputs, so they take effect in the same cycle.
- Freeze condition: dmem_req && !dmem_ready, in RUN or DRAIN.
  - Response: pc_write, if_id_write, id_ex_write, ex_mem_write = 0; mem_wb_write=1 with mem_wb_bubble=1.
  - Next state is MEM_WAIT. The return state (RUN or DRAIN) is remembered.
- MEM_WAIT:
  - Freeze outputs are held and the wait counter increments each cycle.
  - If dmem_ready=1: release in this cycle, meaning normal outputs for the return state, MEM/WB captures, and the next state is the return state.
  - If the wait counter reaches MEM_TIMEOUT: mem_timeout is set (sticky until reset) and waiting continues.
  - Dropping dmem_req while in MEM_WAIT is treated as ready.
- RUN, not frozen, priority order (first match wins):
  1. ex_mispredict: pc_write=1 (target), if_id_flush=1, id_ex_bubble=1; all other stages write. Overrides hazard_stall and id_is_halt, because the younger instructions are squashed.
  2. id_is_halt && !hazard_stall: pc_write=0, if_id_flush=1, ECALL advances into EX. Load the drain counter with DRAIN_CYCLES and go to DRAIN.
  3. hazard_stall: pc_write=0, if_id_write=0, id_ex_bubble=1.
  4. !imem_ready: pc_write=0, if_id_flush=1.
  5. Otherwise all enables are 1 and all flushes/bubbles are 0.
- DRAIN:
  - pc_write=0, if_id_flush=1, downstream stages write.
  - The counter decrements on each non-frozen cycle. ex_mispredict and hazard_stall are ignored.
  - When the counter reaches 0, go to HALTED and set is_halted=1 on that edge.
- HALTED:
  - All *_write=0 and is_halted=1 until reset.
  - The freeze path is ignored.
- Simultaneous mispredict and freeze: freeze wins. EX is held, so ex_mispredict stays asserted and is serviced on the release cycle.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined:
  - stall_cycles counts RUN cycles with hazard_stall applied.
  - flush_count counts mispredict flushes.
  - mem_wait_cycles counts frozen cycles.
  - All three saturate at all-ones and clear on reset.
- When undefined: the counter ports remain and are driven constant 0, with no counter flops.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, DRAIN, HALTED);
  - the default DRAIN_CYCLES and MEM_TIMEOUT constants;
  - the saturating-increment function.
- Sub-module pipe_perf_counters, instantiated only under PIPE_PERF_CNT_EN. It takes the event strobes and outputs the three counters.

Test Plan:
- hazard_stall=1 for 1 cycle in RUN -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; the next cycle returns to all-enabled.
- dmem_req=1, dmem_ready=0 for 4 cycles then 1 -> 4 frozen cycles with mem_wb_bubble=1, release on the 5th; mem_wait_cycles=4 (macro on).
- ex_mispredict=1 together with hazard_stall=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; stall_cycles unchanged, flush_count=1.
- id_is_halt=1 in RUN with DRAIN_CYCLES=3 and a 2-cycle freeze inside the drain -> is_halted rises 5 cycles after leaving RUN, then all *_write=0.
- dmem_ready held 0 for MEM_TIMEOUT=64 cycles -> mem_timeout=1 on cycle 64 and stays 1 after ready.
- reset pulsed low in DRAIN and in MEM_WAIT -> is_halted=0, mem_timeout=0, counters 0 asynchronously; RUN outputs after release.
